adder_s: RTL and testbench

- Lane-parallel accumulate-and-requantize datapath for the matrix-multiply output buffer.
- Adds A_size signed partial-sum lanes to A_size stored accumulator lanes combinationally; the sum feeds accumulator write-back.
- A registered path right-shifts each sum lane and saturates it to the narrow output width for streaming out.
- One sub-module instance per lane performs the shift and saturation.

---
 rtl/adder_s_pkg.sv | 11 +
 rtl/adder_s_if.sv | 18 +
 rtl/adder_s_rshift_sat.sv | 37 +++
 rtl/adder_s.sv | 52 +++++
 tb/tb_adder_s.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/adder_s_pkg.sv
// Shared widths and lane-indexing helper for the accumulate/requantize datapath.
package adder_s_pkg;
    localparam int DATA_WIDTH       = 32;
    localparam int A_SIZE           = 2;
    localparam int AFTER_DATA_WIDTH = 8;
    localparam int SHIFT_WIDTH      = 20;

    function automatic int lane_base(input int i, input int width);
        return i * width;
    endfunction
endpackage

// File: rtl/adder_s_if.sv
// Lane bus between the matmul output buffer and the adder/requantizer.
interface adder_s_if #(
    parameter int DW  = adder_s_pkg::DATA_WIDTH,
    parameter int AS  = adder_s_pkg::A_SIZE,
    parameter int ADW = adder_s_pkg::AFTER_DATA_WIDTH,
    parameter int SW  = adder_s_pkg::SHIFT_WIDTH
);
    logic [AS*DW-1:0]  A;
    logic [AS*DW-1:0]  B;
    logic [AS*DW-1:0]  C;
    logic [SW-1:0]     shift;
    logic              in_valid;
    logic              out_valid;
    logic [AS*ADW-1:0] out_data;

    modport master (output A, B, shift, in_valid, input  C, out_valid, out_data);
    modport slave  (input  A, B, shift, in_valid, output C, out_valid, out_data);
endinterface

// File: rtl/adder_s_rshift_sat.sv
// One lane: arithmetic right shift (floor) followed by signed saturation.
module rshift_sat #(
    parameter int data_width       = 32,
    parameter int after_data_width = 8,
    parameter int shift_width      = 20
) (
    input  logic [shift_width-1:0]      shift,
    input  logic [data_width-1:0]       data_in,
    output logic [after_data_width-1:0] data_out
);
    localparam logic signed [data_width-1:0] MAX_V =
        {{(data_width-after_data_width+1){1'b0}}, {(after_data_width-1){1'b1}}};
    localparam logic signed [data_width-1:0] MIN_V =
        {{(data_width-after_data_width+1){1'b1}}, {(after_data_width-1){1'b0}}};

    logic signed [data_width-1:0] x;
    logic signed [data_width-1:0] y;

    assign x = data_in;

    // Oversized shifts collapse to the sign fill so no shift amount yields X.
    always_comb begin
        y = x;
        if (32'(shift) >= 32'(data_width))
            y = {data_width{x[data_width-1]}};
        else
            y = x >>> shift;
    end

    always_comb begin
        data_out = y[after_data_width-1:0];
        if (y > MAX_V)
            data_out = MAX_V[after_data_width-1:0];
        else if (y < MIN_V)
            data_out = MIN_V[after_data_width-1:0];
    end
endmodule

// File: rtl/adder_s.sv
// Lane-parallel accumulate (combinational C) plus a registered requantize stage.
module adder_s
    import adder_s_pkg::*;
#(
    parameter int data_width       = DATA_WIDTH,
    parameter int A_size           = A_SIZE,
    parameter int after_data_width = AFTER_DATA_WIDTH,
    parameter int shift_width      = SHIFT_WIDTH
) (
    input  logic    clk,
    input  logic    rst_n,
    adder_s_if.slave bus
);
    logic [A_size*after_data_width-1:0] out_data_d;
    logic [A_size*after_data_width-1:0] out_data_q;
    logic                               out_valid_q;

    for (genvar i = 0; i < A_size; i++) begin : g_lane
        localparam int DB = lane_base(i, data_width);
        localparam int OB = lane_base(i, after_data_width);

        logic [data_width-1:0] sum;

        // Plain modulo add: each lane wraps on its own, no carry crosses lanes.
        assign sum = bus.A[DB +: data_width] + bus.B[DB +: data_width];
        assign bus.C[DB +: data_width] = sum;

        rshift_sat #(
            .data_width      (data_width),
            .after_data_width(after_data_width),
            .shift_width     (shift_width)
        ) u_sat (
            .shift   (bus.shift),
            .data_in (sum),
            .data_out(out_data_d[OB +: after_data_width])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid)
                out_data_q <= out_data_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_adder_s.sv
// Self-checking bench for adder_s: directed plan cases plus randomized stream vs a model.
module tb_adder_s;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    adder_s_if #(.DW(32), .AS(2), .ADW(8), .SW(20)) bus ();

    adder_s #(
        .data_width(32), .A_size(2), .after_data_width(8), .shift_width(20)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Reference: 32-bit wrapping sum.
    function automatic int m_sum(input int a, input int b);
        longint s;
        logic [63:0] w;
        s = longint'(a) + longint'(b);
        w = s;
        return int'(w[31:0]);
    endfunction

    // Reference: floor(x / 2^s) then clamp to [-128,127].
    function automatic int m_req(input int x, input int s);
        longint lx, d, y;
        lx = x;
        if (s >= 32) y = (lx < 0) ? -1 : 0;
        else begin
            d = 64'sd1 <<< s;
            if (lx >= 0) y = lx / d;
            else         y = -((-lx + d - 1) / d);
        end
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return int'(y);
    endfunction

    function automatic logic [15:0] pack2(input int e0, input int e1);
        logic [31:0] a, b;
        a = e0; b = e1;
        return {b[7:0], a[7:0]};
    endfunction

    task automatic drive(input int a0, input int a1, input int b0, input int b1,
                         input int s, input logic v);
        bus.A = {a1, a0};
        bus.B = {b1, b0};
        bus.shift = 20'(s);
        bus.in_valid = v;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin
            bad++;
            $display("FAIL reset: got v=%b d=%h want v=0 d=0000", bus.out_valid, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sum();
        int a0, a1, b0, b1;
        logic [63:0] exp;
        @(negedge clk);
        drive(5, -3, 7, 1, 0, 1'b0);
        #1;
        total++;
        exp = {32'hFFFF_FFFE, 32'd12};
        if (bus.C !== exp) begin
            bad++;
            $display("FAIL sum_basic: got %h want %h", bus.C, exp);
        end
        drive(32'h7FFF_FFFF, 100, 1, -40, 0, 1'b0);
        #1;
        total++;
        exp = {32'd60, 32'h8000_0000};
        if (bus.C !== exp) begin
            bad++;
            $display("FAIL sum_wrap: got %h want %h", bus.C, exp);
        end
        for (int k = 0; k < 8; k++) begin
            a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
            drive(a0, a1, b0, b1, 0, 1'b0);
            #1;
            total++;
            exp = {m_sum(a1, b1), m_sum(a0, b0)};
            if (bus.C !== exp) begin
                bad++;
                $display("FAIL sum_rand: got %h want %h", bus.C, exp);
            end
        end
    endtask

    task automatic test_requant();
        int xv[10] = '{1000, 400, -100, -7, -1000, -50, -5, 5, 32'h7FFF_FFFF, 32'h8000_0000};
        int sv[10] = '{2, 2, 2, 2, 2, 0, 40, 40, 31, 1048575};
        int ev[10] = '{127, 100, -25, -2, -128, -50, -1, 0, 0, -1};
        logic [15:0] exp;
        for (int k = 0; k < 10; k += 2) begin
            @(negedge clk);
            drive(xv[k], xv[k+1], 0, 0, sv[k], 1'b1);
            // both lanes share shift; pair entries with the same shift
            if (sv[k] != sv[k+1]) drive(xv[k], 0, 0, 0, sv[k], 1'b1);
            exp = (sv[k] != sv[k+1]) ? pack2(ev[k], 0) : pack2(ev[k], ev[k+1]);
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
                bad++;
                $display("FAIL requant_%0d: got v=%b d=%h want v=1 d=%h", k, bus.out_valid, bus.out_data, exp);
            end
            if (sv[k] != sv[k+1]) begin
                @(negedge clk);
                drive(xv[k+1], 0, 0, 0, sv[k+1], 1'b1);
                exp = pack2(ev[k+1], 0);
                @(posedge clk);
                #1;
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
                    bad++;
                    $display("FAIL requant_%0d: got v=%b d=%h want v=1 d=%h", k+1, bus.out_valid, bus.out_data, exp);
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_burst();
        int vals[3] = '{40, -36, 2000};
        logic [15:0] exp, last;
        last = 16'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(vals[k], -vals[k], 0, 0, 2, 1'b1);
            exp = pack2(m_req(vals[k], 2), m_req(-vals[k], 2));
            last = exp;
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
                bad++;
                $display("FAIL burst_%0d: got v=%b d=%h want v=1 d=%h", k, bus.out_valid, bus.out_data, exp);
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(-999, 999, 0, 0, 0, 1'b0);
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== 1'b0 || bus.out_data !== last) begin
                bad++;
                $display("FAIL burst_hold_%0d: got v=%b d=%h want v=0 d=%h", k, bus.out_valid, bus.out_data, last);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        @(negedge clk);
        drive(300, -300, 0, 0, 1, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin
            bad++;
            $display("FAIL reset_async: got v=%b d=%h want v=0 d=0000", bus.out_valid, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(60, -61, 0, 0, 1, 1'b1);
        exp = pack2(30, -31);
        @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
            bad++;
            $display("FAIL reset_resume: got v=%b d=%h want v=1 d=%h", bus.out_valid, bus.out_data, exp);
        end
    endtask

    task automatic test_random();
        int a0, a1, b0, b1, s;
        logic v;
        logic exp_v;
        logic [15:0] exp_d;
        exp_d = 16'h0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
            if (k % 3 == 0) begin a0 = a0 >>> 20; b0 = b0 >>> 22; a1 = a1 >>> 21; b1 = b1 >>> 23; end
            s = ($urandom_range(0, 7) == 0) ? $urandom_range(32, 1048575) : $urandom_range(0, 31);
            v = (k == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            drive(a0, a1, b0, b1, s, v);
            exp_v = v;
            if (v) exp_d = pack2(m_req(m_sum(a0, b0), s), m_req(m_sum(a1, b1), s));
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== exp_v || bus.out_data !== exp_d) begin
                bad++;
                $display("FAIL random_%0d: got v=%b d=%h want v=%b d=%h", k, bus.out_valid, bus.out_data, exp_v, exp_d);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sum();
        test_requant();
        test_burst();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
